// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings and index-width helper shared by the channel mux
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority search starting at ptr, wrapping at NUM_INPUTS
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    localparam int SEL_W      = clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SEL_W-1:0]      ptr,
    output logic [SEL_W-1:0]      grant,
    output logic                  grant_valid
);

    logic [SEL_W:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // offsets walked high to low so the requester nearest ptr wins last
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (idx >= (SEL_W + 1)'(NUM_INPUTS))
                idx = idx - (SEL_W + 1)'(NUM_INPUTS);
            if (req[idx[SEL_W-1:0]]) begin
                grant       = idx[SEL_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel mux with fixed-select or round-robin grant into one output register
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int  NUM_INPUTS   = 4,
    parameter int  OPERAND_SIZE = 8,
    localparam int SEL_W        = clog2(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_INPUTS*OPERAND_SIZE-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    output logic [NUM_INPUTS-1:0]              in_ready,
    input  logic                               mode,
    input  logic [SEL_W-1:0]                   sel,
    output logic [OPERAND_SIZE-1:0]            out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SEL_W-1:0]                   out_src
);

    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      ptr_next;
    logic [SEL_W-1:0]      rr_grant;
    logic [SEL_W-1:0]      grant;
    logic                  rr_valid;
    logic                  grant_valid;
    logic                  load;
    logic                  xfer;
    logic [2**SEL_W-1:0]   valid_pad;

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // zero-padding makes sel values at or beyond NUM_INPUTS read as not valid
    assign valid_pad   = (2**SEL_W)'(in_valid);
    assign load        = !out_valid || out_ready;
    assign grant       = (mode == MODE_RR) ? rr_grant : sel;
    assign grant_valid = (mode == MODE_RR) ? rr_valid : valid_pad[sel];
    assign xfer        = rst_n && load && grant_valid;
    assign in_ready    = xfer ? NUM_INPUTS'(1) << grant : '0;
    assign ptr_next    = (grant == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out_data  <= in_data[grant*OPERAND_SIZE +: OPERAND_SIZE];
            out_src   <= grant;
            out_valid <= 1'b1;
            if (mode == MODE_RR)
                ptr <= ptr_next;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter: NUM_INPUTS, default 4, number of input channels (2..16).
REQ-002 Parameter: OPERAND_SIZE, default 8, data width per channel.
REQ-003 Derived constant: SEL_W = clog2(NUM_INPUTS), minimum 1.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  single rising-edge clock.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: in_data  in  NUM_INPUTS*OPERAND_SIZE  channel i occupies bits [i*OPERAND_SIZE +: OPERAND_SIZE].
REQ-008 Port: in_valid  in  NUM_INPUTS  per-channel data-valid.
REQ-009 Port: in_ready  out  NUM_INPUTS  per-channel accept; one-hot or zero.
REQ-010 Port: mode  in  1  selection mode; 0 = SEL (fixed select), 1 = RR (round-robin).
REQ-011 Port: sel  in  SEL_W  channel index, used in SEL mode only.
REQ-012 Port: out_data  out  OPERAND_SIZE  registered selected word.
REQ-013 Port: out_valid  out  1  out_data holds a word.
REQ-014 Port: out_ready  in  1  downstream accept.
REQ-015 Port: out_src  out  SEL_W  channel index of the word in out_data.

Function
REQ-016 The block SHALL hold a single output register stage; load = !out_valid || out_ready.
REQ-017 In SEL mode, the grant SHALL be channel sel when in_valid[sel]=1 and sel<NUM_INPUTS; otherwise there is no grant.
REQ-018 In RR mode, the grant SHALL be the first channel with in_valid=1, searching ptr, ptr+1, ... modulo NUM_INPUTS.
REQ-019 Transfer SHALL occur when load=1 and a grant exists; in_ready[g]=1 for granted channel g only, and all other in_ready bits SHALL be 0.
REQ-020 On transfer: out_data <= granted word, out_src <= g, out_valid <= 1 on the next edge (latency 1 cycle, throughput 1 word/cycle).
REQ-021 When load=1 and there is no grant, out_valid SHALL become 0 on the next edge, and out_data/out_src SHALL hold their values.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL remain stable, and in_ready SHALL be all 0.
REQ-023 ptr SHALL update to (g+1) mod NUM_INPUTS on each RR-mode transfer only, and SHALL remain unchanged in SEL mode or without transfer.
REQ-024 A mode or sel change SHALL affect only the next grant; a held word SHALL be unaffected.
REQ-025 in_ready SHALL NOT depend on in_data; the combinational path from out_ready and in_valid to in_ready is permitted.
REQ-026 Non-power-of-two NUM_INPUTS: sel values of NUM_INPUTS or above SHALL give no grant, and ptr wraparound SHALL skip indices of NUM_INPUTS or above.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_src=0, ptr=0, in_ready=all 0, immediately and independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; the first RR grant after release SHALL search from channel 0.

Structure
REQ-029 Shared package mux_pkg SHALL hold MODE_SEL=1'b0, MODE_RR=1'b1 and the clog2 helper function.
REQ-030 Sub-module rr_arbiter (NUM_INPUTS parameter; in: req, ptr; out: grant index, grant_valid) SHALL implement the rotating priority search; the top level SHALL own ptr and the output register.

Verification (NUM_INPUTS=4, OPERAND_SIZE=8)
REQ-031 SEL mode; in_data ch0..3 = 11,22,33,44; all valid; sel=2; out_ready=1 -> in_ready=0100; next cycle out_data=0x33, out_src=2, out_valid=1.
REQ-032 RR mode, all valid, out_ready=1 held -> out_src sequence 0,1,2,3,0 with out_data 11,22,33,44,11 on consecutive cycles.
REQ-033 RR mode, only ch1 and ch3 valid -> out_src alternates 1,3,1,3; in_ready[0] and in_ready[2] are never 1.
REQ-034 Backpressure: out_valid=1 with out_data=0x22, out_ready=0 for 3 cycles -> out_data stays 0x22 and in_ready=0000 throughout; out_ready=1 -> next channel (2) loads.
REQ-035 SEL mode, sel=1, in_valid=1101, out_ready=1 -> in_ready=0000 and out_valid falls to 0 after the held word drains.
REQ-036 rst_n pulsed low mid-stream in RR with out_src=2 -> out_valid=0 and out_data=0x00 asynchronously; after release, first out_src=0.
